// File: rtl/obu_parser_pkg.sv
// Shared types and constants for the OBU parsing pipeline.
// Latency: none, declarations only.
// Backpressure: not applicable.
package obu_parser_pkg;

   localparam int PARSER_DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      OBU_SEQUENCE_HEADER    = 4'd1,
      OBU_TEMPORAL_DELIMITER = 4'd2,
      OBU_FRAME_HEADER       = 4'd3,
      OBU_TILE_GROUP         = 4'd4,
      OBU_METADATA           = 4'd5,
      OBU_FRAME              = 4'd6,
      OBU_PADDING            = 4'd15
   } obu_type_e;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HDR_WAIT = 3'd1,
      S_DISPATCH = 3'd2,
      S_PAYLOAD  = 3'd3,
      S_SKIP     = 3'd4,
      S_DONE     = 3'd5
   } ctrl_state_e;

   localparam int SINK_IDX_W = 2;

   localparam logic [SINK_IDX_W-1:0] SINK_SEQ_HDR     = 2'd0;
   localparam logic [SINK_IDX_W-1:0] SINK_FRAME_HDR   = 2'd1;
   localparam logic [SINK_IDX_W-1:0] SINK_FRAME       = 2'd2;
   localparam logic [SINK_IDX_W-1:0] SINK_TILE_GROUP  = 2'd3;

endpackage

// File: rtl/obu_type_router.sv
// Maps an obu_type to the payload sink that consumes it, or flags it as skipped.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module obu_type_router
   import obu_parser_pkg::*;
(
   input  logic [3:0]            obu_type_i,
   output logic                  route_vld_o,
   output logic [SINK_IDX_W-1:0] sink_idx_o
);

   // Only four types have a dedicated sink; everything else is drained.
   always_comb begin
      route_vld_o = 1'b0;
      sink_idx_o  = SINK_SEQ_HDR;
      case (obu_type_i)
         OBU_SEQUENCE_HEADER: begin route_vld_o = 1'b1; sink_idx_o = SINK_SEQ_HDR;    end
         OBU_FRAME_HEADER:    begin route_vld_o = 1'b1; sink_idx_o = SINK_FRAME_HDR;  end
         OBU_FRAME:           begin route_vld_o = 1'b1; sink_idx_o = SINK_FRAME;      end
         OBU_TILE_GROUP:      begin route_vld_o = 1'b1; sink_idx_o = SINK_TILE_GROUP; end
         default:             begin route_vld_o = 1'b0; sink_idx_o = SINK_SEQ_HDR;    end
      endcase
   end

endmodule

// File: rtl/obu_stream_ctrl.sv
// Sequences one OBU at a time: header parse, payload dispatch or skip, completion count.
// Latency: hdr_done to obu_done is 2 cycles for an empty payload, otherwise payload-driven.
// Backpressure: owns the only FIFO pop; the skip engine stalls while avail is low.
module obu_stream_ctrl
   import obu_parser_pkg::*;
#(
   parameter int DATA_WIDTH = PARSER_DATA_WIDTH,
   parameter int SIZE_WIDTH = 56,
   parameter int NUM_SINKS  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  avail,
   output logic                  stream_pop,
   output logic                  hdr_start,
   input  logic                  hdr_pop,
   input  logic                  hdr_done,
   input  logic [3:0]            hdr_obu_type,
   input  logic [SIZE_WIDTH-1:0] hdr_obu_size,
   output logic [NUM_SINKS-1:0]  sink_start,
   input  logic [NUM_SINKS-1:0]  sink_pop,
   input  logic [NUM_SINKS-1:0]  sink_done,
   output logic [3:0]            obu_type,
   output logic                  busy,
   output logic                  obu_done,
   output logic [CNT_WIDTH-1:0]  obu_count,
   output logic                  err_overrun
);

   localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);
   localparam int REM_W          = SIZE_WIDTH - 1;

   ctrl_state_e            state_q, state_d;
   logic [REM_W-1:0]       words_rem_q, words_rem_d;
   logic [3:0]             obu_type_q, obu_type_d;
   logic [CNT_WIDTH-1:0]   obu_count_q, obu_count_d;
   logic                   err_q, err_d;

   logic                   route_vld;
   logic [SINK_IDX_W-1:0]  route_idx;
   logic [SIZE_WIDTH:0]    size_round;
   logic [REM_W-1:0]       words_load;
   logic [REM_W-1:0]       rem_dec;

   // The route follows the latched type, so it is stable for the whole OBU.
   obu_type_router u_router (
      .obu_type_i  (obu_type_q),
      .route_vld_o (route_vld),
      .sink_idx_o  (route_idx)
   );

   // Payload bytes rounded up to whole stream words; the extra bit absorbs the carry.
   assign size_round = {1'b0, hdr_obu_size} + (SIZE_WIDTH+1)'(BYTES_PER_WORD - 1);
   assign words_load = REM_W'(size_round >> WORD_SHIFT);
   assign rem_dec    = (words_rem_q == '0) ? '0 : words_rem_q - REM_W'(1);

   // Next-state, pop mux and per-OBU word accounting.
   always_comb begin
      state_d     = state_q;
      words_rem_d = words_rem_q;
      obu_type_d  = obu_type_q;
      obu_count_d = obu_count_q;
      err_d       = err_q;
      stream_pop  = 1'b0;
      hdr_start   = 1'b0;
      sink_start  = '0;
      obu_done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable && avail) begin
               hdr_start = 1'b1;
               state_d   = S_HDR_WAIT;
            end
         end
         S_HDR_WAIT: begin
            stream_pop = hdr_pop;
            if (hdr_done) begin
               obu_type_d  = hdr_obu_type;
               words_rem_d = words_load;
               state_d     = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            if (words_rem_q == '0) begin
               state_d = S_DONE;
            end else if (route_vld) begin
               sink_start[route_idx] = 1'b1;
               state_d               = S_PAYLOAD;
            end else begin
               state_d = S_SKIP;
            end
         end
         S_PAYLOAD: begin
            stream_pop = sink_pop[route_idx];
            if (stream_pop) begin
               words_rem_d = rem_dec;
               if (words_rem_q == '0) begin
                  err_d = 1'b1;
               end
            end
            // Same-cycle pop is already folded into words_rem_d.
            if (sink_done[route_idx]) begin
               state_d = (words_rem_d == '0) ? S_DONE : S_SKIP;
            end
         end
         S_SKIP: begin
            stream_pop = avail;
            if (avail) begin
               words_rem_d = rem_dec;
               if (words_rem_q == REM_W'(1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            obu_done    = 1'b1;
            obu_count_d = obu_count_q + CNT_WIDTH'(1);
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and accounting registers; reset abandons any OBU in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         words_rem_q <= '0;
         obu_type_q  <= '0;
         obu_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         words_rem_q <= words_rem_d;
         obu_type_q  <= obu_type_d;
         obu_count_q <= obu_count_d;
         err_q       <= err_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign obu_type    = obu_type_q;
   assign obu_count   = obu_count_q;
   assign err_overrun = err_q;

endmodule

// File: doc/obu_stream_ctrl.md
Name: obu_stream_ctrl

Overview:
- Top-level sequencer for the OBU parsing pipeline.
- Starts the OBU header parser and captures obu_type/obu_size when the header completes.
- Routes the payload words to the matching payload sink (sequence header, frame header, frame, tile group), or drops the payload for unsupported types.
- Owns the single stream_pop to the input word FIFO and muxes pops between header parser, active sink and its own skip engine; keeps per-OBU word accounting and reports overrun.

Parameters:
- DATA_WIDTH, 32 (= PARSER_DATA_WIDTH): stream word width in bits.
- SIZE_WIDTH, 56: width of obu_size in bytes (leb128 result).
- NUM_SINKS, 4: number of payload sinks.
- CNT_WIDTH, 16: width of obu_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  allow a new OBU to start
- avail  in  1  input FIFO has a word at head
- stream_pop  out  1  pop the FIFO head word
- hdr_start  out  1  one-cycle start pulse to the header parser
- hdr_pop  in  1  header parser pop request
- hdr_done  in  1  header parser done; obu_type/obu_size valid this cycle
- hdr_obu_type  in  4  obu_type field
- hdr_obu_size  in  SIZE_WIDTH  payload bytes
- sink_start  out  NUM_SINKS  one-hot start pulse
- sink_pop  in  NUM_SINKS  per-sink pop requests
- sink_done  in  NUM_SINKS  per-sink done pulses
- obu_type  out  4  latched type of the current OBU
- busy  out  1  state != IDLE
- obu_done  out  1  one-cycle pulse per completed OBU
- obu_count  out  CNT_WIDTH  completed OBUs, wraps
- err_overrun  out  1  sticky: a pop occurred with words_rem == 0

Behaviour:
- Reset: all outputs 0, state IDLE, words_rem 0, obu_count 0. rst_n low on any edge, including mid-OBU, forces IDLE on that edge and discards the OBU in progress.
- Stream contract, enforced by upstream: every payload starts word-aligned after the header pad and is zero-padded to a word boundary.
- words_rem = (hdr_obu_size + 3) >> 2, width SIZE_WIDTH-1, loaded on hdr_done. Decrement is saturating at 0.
- IDLE:
  - If enable && avail: hdr_start=1 combinationally in this cycle, then go to HDR_WAIT.
  - Otherwise stream_pop=0.
- HDR_WAIT:
  - stream_pop = hdr_pop.
  - On hdr_done: latch obu_type and words_rem, go to DISPATCH. hdr_done and hdr_pop in the same cycle is legal; the pop is passed through.
- DISPATCH (1 cycle, stream_pop=0):
  - If words_rem == 0: go to DONE.
  - Else if the type maps to a sink: sink_start[idx]=1 for this cycle only, go to PAYLOAD.
  - Else: go to SKIP.
  - Map (constants in the package): type 1→sink0, 3→sink1, 6→sink2, 4→sink3. All other types (2, 5, 7, 8, 15, reserved) skip.
- PAYLOAD:
  - stream_pop = sink_pop[idx]; pops from non-selected sinks are ignored.
  - Each pop decrements words_rem. A pop with words_rem == 0 sets err_overrun; the pop is still forwarded.
  - On sink_done[idx], with any same-cycle pop counted first: go to DONE if the result is 0, else go to SKIP to drain trailing words.
- SKIP:
  - stream_pop = avail; each pop decrements words_rem.
  - A pop that takes words_rem 1→0 moves to DONE. No pop while avail=0 (stall).
- DONE (1 cycle): obu_done=1, obu_count+=1 (wraps), go to IDLE. The next OBU hdr_start is possible no earlier than the following cycle.
- stream_pop is never asserted while avail=0 by the skip engine; hdr/sink pops are assumed already gated by avail.
- Latency for a mapped, 0-byte OBU: hdr_done → obu_done is 2 cycles (DISPATCH, DONE).

Decomposition:
- Package obu_parser_pkg:
  - obu_type_e enum (OBU_SEQUENCE_HEADER=1, OBU_TEMPORAL_DELIMITER=2, OBU_FRAME_HEADER=3, OBU_TILE_GROUP=4, OBU_METADATA=5, OBU_FRAME=6, OBU_PADDING=15).
  - ctrl_state_e.
  - SINK_* index constants.
  - Reuse of PARSER_DATA_WIDTH.
- One natural sub-module: obu_type_router, a combinational function of type → {valid, sink index}.
- The word counter lives in the FSM module.

Test Plan:
- Type 1, size 10 (3 words); sink0 pops 3 words then raises done → sink_start=0001, 3 stream_pops, obu_done, obu_count=1, err_overrun=0.
- Type 2 (temporal delimiter), size 0 → no sink_start; DISPATCH→DONE; obu_done 2 cycles after hdr_done.
- Type 5, size 9, with avail dropped for 2 cycles mid-skip → exactly 3 pops, none while avail=0, then obu_done.
- Type 6, size 16; sink2 pops 2 words and raises done → SKIP drains 2 more words; total 4 pops.
- Type 3, size 4; sink1 pops 2 words → err_overrun=1 on the second pop and stays set.
- rst_n low for 1 cycle during PAYLOAD → next cycle busy=0, outputs 0, obu_count=0; a following OBU parses normally.
